// File: rtl/crop_unit.sv
// crop_unit: extracts an OUT_H x OUT_W window from a padded IN_H x IN_W tile
// at a programmable (crop_top, crop_left) offset, one output row per cycle.
// Window positions outside the input tile take fill_value and raise crop_err.
module crop_unit #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IN_H   = 10,
  parameter int unsigned IN_W   = 10,
  parameter int unsigned OUT_H  = 8,
  parameter int unsigned OUT_W  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [IN_H*IN_W*DATA_W-1:0]      data_in,
  input  logic                             valid_in,
  output logic                             ready_in,
  input  logic [3:0]                       crop_top,
  input  logic [3:0]                       crop_left,
  input  logic [DATA_W-1:0]                fill_value,
  output logic [OUT_H*OUT_W*DATA_W-1:0]    data_out,
  output logic                             valid_out,
  input  logic                             ready_out,
  output logic                             crop_err
);

  localparam int unsigned IN_N  = IN_H * IN_W;
  localparam int unsigned ROW_W = OUT_W * DATA_W;
  localparam int unsigned RW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int unsigned IW    = (IN_N > 1) ? $clog2(IN_N) : 1;
  // Source coordinates are wide enough that offset + index never wraps.
  localparam int unsigned SW    = 8;

  localparam logic [SW-1:0] IN_H_S   = SW'(IN_H);
  localparam logic [SW-1:0] IN_W_S   = SW'(IN_W);
  localparam logic [RW-1:0] LAST_ROW = RW'(OUT_H - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CROP   = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] tile_buf [IN_N];
  logic [ROW_W-1:0]  out_rows [OUT_H];
  logic [3:0]        top_q;
  logic [3:0]        left_q;
  logic [DATA_W-1:0] fill_q;
  logic [RW-1:0]     row_cnt;

  logic              accept;
  logic              step;
  logic              drain;
  logic [ROW_W-1:0]  row_data;
  logic              row_err;
  logic [SW-1:0]     src_r;
  logic [SW-1:0]     src_c;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    drain     = 1'b0;
    case (state)
      IDLE: begin
        if (valid_in && ready_in) begin
          accept    = 1'b1;
          state_nxt = CROP;
        end
      end
      CROP: begin
        step = 1'b1;
        if (row_cnt == LAST_ROW) state_nxt = OUTPUT;
      end
      OUTPUT: begin
        if (ready_out) begin
          drain     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        // Illegal encoding: drop any output and reopen the input side.
        drain     = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  // Build the current output row from the buffered tile, with fill for out-of-range sources.
  always_comb begin
    row_data = '0;
    row_err  = 1'b0;
    src_c    = '0;
    src_r    = SW'(top_q) + SW'(row_cnt);
    for (int c = 0; c < int'(OUT_W); c++) begin
      src_c = SW'(left_q) + SW'(c);
      if ((src_r < IN_H_S) && (src_c < IN_W_S)) begin
        row_data[c*DATA_W +: DATA_W] = tile_buf[IW'(32'(src_r) * IN_W + 32'(src_c))];
      end else begin
        row_data[c*DATA_W +: DATA_W] = fill_q;
        row_err                      = 1'b1;
      end
    end
  end

  // Tile buffer: pure datapath, only meaningful after an accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < int'(IN_N); i++) begin
        tile_buf[i] <= data_in[DATA_W*i +: DATA_W];
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < int'(OUT_H); r++) out_rows[r] <= '0;
      top_q     <= '0;
      left_q    <= '0;
      fill_q    <= '0;
      row_cnt   <= '0;
      valid_out <= 1'b0;
      crop_err  <= 1'b0;
      ready_in  <= 1'b1;
    end else begin
      if (accept) begin
        top_q    <= crop_top;
        left_q   <= crop_left;
        fill_q   <= fill_value;
        row_cnt  <= '0;
        crop_err <= 1'b0;
        ready_in <= 1'b0;
      end
      if (step) begin
        out_rows[row_cnt] <= row_data;
        row_cnt           <= row_cnt + RW'(1);
        if (row_err) crop_err <= 1'b1;
        if (row_cnt == LAST_ROW) valid_out <= 1'b1;
      end
      if (drain) begin
        valid_out <= 1'b0;
        ready_in  <= 1'b1;
      end
    end
  end

  // Flatten the row registers onto the row-major output bus.
  for (genvar r = 0; r < int'(OUT_H); r++) begin : g_out
    assign data_out[r*ROW_W +: ROW_W] = out_rows[r];
  end

endmodule

// File: doc/crop_unit.md
Name: crop_unit

Overview:
- Inverse of the padding stage. Accepts one padded IN_H x IN_W tile of DATA_W-bit elements and extracts an OUT_H x OUT_W window at a programmable (crop_top, crop_left) offset.
- Sits in the data_ops path after conv/pool stages, to strip halo rows and columns before writeback.
- Works on one tile at a time: valid/ready input handshake, one output row per cycle, registered output tile held until consumed.

Parameters:
- DATA_W, 16, element width in bits
- IN_H, 10, input tile rows
- IN_W, 10, input tile columns
- OUT_H, 8, output tile rows
- OUT_W, 8, output tile columns

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  asynchronous reset, active-high
- data_in  input  IN_H*IN_W*DATA_W  input tile, row-major; element i (row i/IN_W, col i%IN_W) at bits [DATA_W*i +: DATA_W]
- valid_in  input  1  input tile valid
- ready_in  output  1  block can accept a tile
- crop_top  input  4  first source row of the window
- crop_left  input  4  first source column of the window
- fill_value  input  DATA_W  value substituted for window positions that fall outside the input tile
- data_out  output  OUT_H*OUT_W*DATA_W  output tile, row-major, same packing as data_in
- valid_out  output  1  output tile valid
- ready_out  input  1  downstream accepts the tile
- crop_err  output  1  at least one window element fell outside the input tile; qualified by valid_out

Behaviour:
- Reset (rst=1, async, any state): data_out=0, valid_out=0, crop_err=0, ready_in=1, row_cnt=0, state=IDLE. Any in-flight tile is discarded.
- States: IDLE, CROP, OUTPUT. All outputs are registered.
- IDLE:
  - ready_in=1.
  - On an edge with valid_in && ready_in: capture data_in into an internal buffer; capture crop_top, crop_left and fill_value.
  - On that same edge: row_cnt<=0, crop_err<=0, ready_in<=0, state<=CROP.
- CROP, one output row per cycle, for r=row_cnt:
  - For each c in 0..OUT_W-1: src_r = crop_top + r, src_c = crop_left + c, computed at least 6 bits wide with no wrap.
  - If src_r<IN_H and src_c<IN_W: out[r*OUT_W+c] <= buf[src_r*IN_W+src_c].
  - Otherwise: out[r*OUT_W+c] <= fill_value, and crop_err <= 1 (sticky for the tile).
  - row_cnt increments each cycle.
  - When row_cnt==OUT_H-1: valid_out<=1, state<=OUTPUT.
- OUTPUT:
  - data_out, crop_err and valid_out are held stable while ready_out=0.
  - On an edge with ready_out=1: valid_out<=0, ready_in<=1, state<=IDLE.
- Latency and throughput:
  - Accept on edge N; valid_out is first high after edge N+OUT_H (8 with defaults).
  - With ready_out tied high, a new tile is accepted every OUT_H+2 cycles (10).
- valid_in, data_in and offsets are ignored outside IDLE. Offsets are sampled only at accept.
- data_out is updated row by row during CROP. Downstream must only sample it when valid_out=1.
- Default state encoding recovers to IDLE.
- No combinational path from any input to any output.

Test Plan:
- Centre crop: data_in[i]=i, crop_top=1, crop_left=1 -> valid_out 8 cycles after accept; out[0]=11, out[7]=18, out[63]=88; crop_err=0.
- Origin crop: same tile, offsets (0,0) -> out[0]=0, out[8]=10, out[63]=77; crop_err=0.
- Out of bounds: offsets (2,3), fill_value=0xFFFF:
  - out[0]=23, out[6]=29.
  - out[7], out[15], ..., out[63] = 0xFFFF (source col 10).
  - crop_err=1.
  - A following in-bounds tile returns crop_err=0.
- Backpressure: ready_out=0 for 5 cycles after valid_out rises -> valid_out, data_out and crop_err stable; ready_in=0; a valid_in pulse with different data is ignored. Release -> one transfer, ready_in=1 the next cycle.
- Back-to-back: ready_out tied 1, valid_in held with two tiles -> accepts at cycles 0 and 10; outputs valid at cycles 8 and 18, each for exactly one cycle.
- Reset mid-operation: rst asserted during CROP after 3 rows, and separately during OUTPUT -> immediately valid_out=0, crop_err=0, data_out=0, ready_in=1. After rst deasserts, the next tile is processed correctly.
